// File: rtl/tick_pkg.sv
// Shared types for the tick sequencing controller.
// FSM states and mode encodings.
package tick_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_e;

  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;

  function automatic logic is_periodic(input logic m);
    return m == MODE_PERIODIC;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running prescaler: counts enabled cycles, wraps on
// equality with the divide value and flags the wrap cycle.
module tick_prescaler #(
  parameter int CNT_W = 26
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic             i_clr,
  input  logic [CNT_W-1:0] i_div,
  output logic             o_pulse
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             hit;

  // Equality wrap only; count never exceeds the divide value.
  assign hit     = (cnt_q == i_div);
  assign o_pulse = i_en & hit;

  always_comb begin
    cnt_d = cnt_q;
    if (i_clr) begin
      cnt_d = '0;
    end else if (i_en) begin
      cnt_d = hit ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/tick_seq_ctrl.sv
// Tick sequencing controller: latches a run setup and counts
// prescaler ticks into rounds, one-shot or periodic.
module tick_seq_ctrl
  import tick_pkg::*;
#(
  parameter int CNT_W   = 26,
  parameter int TCK_W   = 8,
  parameter int DIV_RST = 10_000_000
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic             i_stop,
  input  logic             i_ce,
  input  logic             i_mode,
  input  logic [CNT_W-1:0] i_div,
  input  logic [TCK_W-1:0] i_ticks,
  output logic             o_busy,
  output logic             o_tick,
  output logic             o_done,
  output logic [TCK_W-1:0] o_tick_cnt
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] div_q, div_d;
  logic [TCK_W-1:0] ticks_q, ticks_d;
  logic             mode_q, mode_d;
  logic [TCK_W-1:0] tcnt_q, tcnt_d;
  logic [TCK_W-1:0] tcnt_inc;
  logic             tick_q, tick_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic             active;
  logic             pre_en;
  logic             pre_clr;
  logic             pulse;

  assign active   = (state_q == RUN) | (state_q == PAUSE);
  assign pre_en   = active & i_ce & ~i_stop;
  assign pre_clr  = i_stop | ((state_q == IDLE) & i_start);
  assign tcnt_inc = tcnt_q + TCK_W'(1);

  tick_prescaler #(
    .CNT_W(CNT_W)
  ) u_pre (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_en   (pre_en),
    .i_clr  (pre_clr),
    .i_div  (div_q),
    .o_pulse(pulse)
  );

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    ticks_d = ticks_q;
    mode_d  = mode_q;
    tcnt_d  = tcnt_q;
    tick_d  = 1'b0;
    done_d  = 1'b0;
    // Busy trails the state by one edge so it drops after done.
    busy_d  = active;
    if (i_stop) begin
      state_d = IDLE;
      tcnt_d  = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (i_start) begin
            div_d   = i_div;
            ticks_d = i_ticks;
            mode_d  = i_mode;
            tcnt_d  = '0;
            if (i_ticks == '0) begin
              done_d = 1'b1;
            end else begin
              state_d = RUN;
            end
          end
        end
        RUN, PAUSE: begin
          if (!i_ce) begin
            state_d = PAUSE;
          end else begin
            state_d = RUN;
            if (pulse) begin
              tick_d = 1'b1;
              if (tcnt_inc == ticks_q) begin
                done_d = 1'b1;
                tcnt_d = '0;
                if (!is_periodic(mode_q)) begin
                  state_d = IDLE;
                end
              end else begin
                tcnt_d = tcnt_inc;
              end
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      div_q   <= CNT_W'(DIV_RST);
      ticks_q <= '0;
      mode_q  <= MODE_ONESHOT;
      tcnt_q  <= '0;
      tick_q  <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      ticks_q <= ticks_d;
      mode_q  <= mode_d;
      tcnt_q  <= tcnt_d;
      tick_q  <= tick_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign o_busy     = busy_q;
  assign o_tick     = tick_q;
  assign o_done     = done_q;
  assign o_tick_cnt = tcnt_q;

endmodule
